// File: rtl/debounce_pkg.sv
// Shared definitions for the push-button debouncer.
//   state_e                 : 2-bit FSM state encoding
//                             (IDLE_LOW=00, WAIT_HIGH=01, IDLE_HIGH=10, WAIT_LOW=11)
//   DEFAULT_DEBOUNCE_CYCLES : default qualification length in clock cycles
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'b00,
    WAIT_HIGH = 2'b01,
    IDLE_HIGH = 2'b10,
    WAIT_LOW  = 2'b11
  } state_e;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

endpackage

// File: rtl/input_synchronizer.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Ports:
//   clock : system clock, rising edge
//   reset : synchronous active-high reset, clears both flops to 0
//   d     : asynchronous input
//   q     : synchronized output, two cycles behind d
module input_synchronizer (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/button_debouncer.sv
// Push-button debouncer. A new input level must be seen on DEBOUNCE_CYCLES+1
// consecutive sampling edges before btn_out follows it; any opposite sample
// restarts the qualification.
// Ports:
//   clock   : system clock, rising edge
//   reset   : synchronous active-high reset
//   btn_in  : raw bouncing button level
//   btn_out : registered debounced level
//   busy    : registered, high while a level change is being qualified
// Build option: define BUTTON_DEBOUNCER_SYNC_EN to insert a two-flop
// synchronizer on btn_in (adds two cycles of latency). Without it btn_in is
// sampled directly, which is only safe for synchronous stimulus.
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_in,
  output logic btn_out,
  output logic busy
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_param
    $error("button_debouncer: DEBOUNCE_CYCLES must be at least 1");
  end

  // Guarded so an illegal parameter still yields a legal width while the
  // elaboration error above is reported.
  localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
      (DEBOUNCE_CYCLES < 1) ? '0 : CNT_W'(DEBOUNCE_CYCLES - 1);

  logic s;

`ifdef BUTTON_DEBOUNCER_SYNC_EN
  input_synchronizer u_sync (
    .clock (clock),
    .reset (reset),
    .d     (btn_in),
    .q     (s)
  );
`else
  assign s = btn_in;
`endif

  state_e           state;
  logic [CNT_W-1:0] cnt;

  // busy and btn_out are registered alongside the state so they always match
  // the state they describe.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE_LOW;
      cnt     <= '0;
      btn_out <= 1'b0;
      busy    <= 1'b0;
    end else begin
      unique case (state)
        IDLE_LOW: begin
          if (s) begin
            state <= WAIT_HIGH;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (!s) begin
            state   <= IDLE_LOW;
            cnt     <= '0;
            busy    <= 1'b0;
            btn_out <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state   <= IDLE_HIGH;
            cnt     <= '0;
            busy    <= 1'b0;
            btn_out <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        IDLE_HIGH: begin
          if (!s) begin
            state <= WAIT_LOW;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        WAIT_LOW: begin
          if (s) begin
            state   <= IDLE_HIGH;
            cnt     <= '0;
            busy    <= 1'b0;
            btn_out <= 1'b1;
          end else if (cnt == CNT_LAST) begin
            state   <= IDLE_LOW;
            cnt     <= '0;
            busy    <= 1'b0;
            btn_out <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE_LOW;
          cnt     <= '0;
          busy    <= 1'b0;
          btn_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer with DEBOUNCE_CYCLES=4.
// A run-length model (count of consecutive samples differing from the
// debounced level) is compared against the DUT after every rising edge;
// directed sequences pin both the DUT and the model to literal timings.
module tb_button_debouncer;

  localparam int D = 4;
`ifdef BUTTON_DEBOUNCER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clock;
  logic reset;
  logic btn_in;
  logic btn_out;
  logic busy;

  int n_vec;
  int n_fail;

  button_debouncer #(
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .btn_in  (btn_in),
    .btn_out (btn_out),
    .busy    (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: run = consecutive post-reset samples unequal to the
  // debounced level; the level flips once that run reaches D+1.
  int   m_run;
  logic m_out;
  logic m_busy;
  logic p1, p2;

  initial begin
    m_run  = 0;
    m_out  = 1'b0;
    m_busy = 1'b0;
    p1     = 1'b0;
    p2     = 1'b0;
  end

  always @(posedge clock) begin
    logic s_m;
    if (reset) begin
      m_out = 1'b0;
      m_run = 0;
      p1    = 1'b0;
      p2    = 1'b0;
    end else begin
`ifdef BUTTON_DEBOUNCER_SYNC_EN
      s_m = p2;
      p2  = p1;
      p1  = btn_in;
`else
      s_m = btn_in;
`endif
      if (s_m != m_out) begin
        m_run++;
        if (m_run == D + 1) begin
          m_out = s_m;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
    end
    m_busy = (m_run != 0);
    #1;
    check("model_btn_out", btn_out, m_out);
    check("model_busy", busy, m_busy);
  end

  // Downstream rising-edge detector fed by the debounced level.
  logic det_prev;
  logic det_pulse;
  int   pulse_cnt;
  initial pulse_cnt = 0;

  always @(posedge clock) begin
    if (reset) begin
      det_prev  <= 1'b0;
      det_pulse <= 1'b0;
    end else begin
      det_prev  <= btn_out;
      det_pulse <= btn_out & ~det_prev;
    end
  end

  always @(negedge clock) if (det_pulse === 1'b1) pulse_cnt++;

  // Hold btn_in at lvl and check btn_out / busy after each edge.
  task automatic qualify(input logic lvl, input string tag);
    btn_in = lvl;
    for (int i = 1; i <= D + 1 + LAT; i++) begin
      logic exp_out;
      logic exp_busy;
      @(negedge clock);
      exp_out  = (i >= D + 1 + LAT) ? lvl : ~lvl;
      exp_busy = (i > LAT) && (i <= LAT + D);
      check({tag, "_out"}, btn_out, exp_out);
      check({tag, "_busy"}, busy, exp_busy);
      check({tag, "_model"}, m_out, exp_out);
    end
  endtask

  logic pat [9];
  int   pulses_before;
  int   run_left;
  logic lvl;

  initial begin
    n_vec  = 0;
    n_fail = 0;
    reset  = 1'b1;
    btn_in = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_btn_out", btn_out, 1'b0);
    check("reset_busy", busy, 1'b0);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    // Clean press.
    qualify(1'b1, "press");

    // Three-cycle low glitch must not release the button.
    for (int i = 1; i <= 3 + LAT + D + 2; i++) begin
      btn_in = (i <= 3) ? 1'b0 : 1'b1;
      @(negedge clock);
      check("glitch_low_out", btn_out, 1'b1);
    end

    // Clean release.
    qualify(1'b0, "release");
    repeat (3) @(negedge clock);

    // Bouncy press through the edge detector.
    pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    pulses_before = pulse_cnt;
    for (int i = 1; i <= 9 + LAT; i++) begin
      int   j;
      logic exp_busy;
      btn_in = (i <= 9) ? pat[i-1] : 1'b1;
      @(negedge clock);
      j = i - LAT;
      exp_busy = ((j >= 1) && (j <= 3)) || ((j >= 5) && (j <= 8));
      check("bounce_out", btn_out, (j >= 9) ? 1'b1 : 1'b0);
      check("bounce_busy", busy, exp_busy);
    end
    repeat (4) @(negedge clock);
    check("chain_one_pulse", (pulse_cnt - pulses_before) == 1, 1'b1);

    // Release, then reset in the middle of a press qualification.
    btn_in = 1'b0;
    repeat (D + LAT + 4) @(negedge clock);
    check("pre_reset_out", btn_out, 1'b0);
    btn_in = 1'b1;
    repeat (3 + LAT) @(negedge clock);
    check("midwait_busy", busy, 1'b1);
    reset = 1'b1;
    @(negedge clock);
    check("midreset_out", btn_out, 1'b0);
    check("midreset_busy", busy, 1'b0);
    reset = 1'b0;
    qualify(1'b1, "post_reset");

    // Randomized bouncing runs with occasional resets.
    run_left = 0;
    lvl      = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (run_left == 0) begin
        lvl      = $urandom_range(0, 1) == 1;
        run_left = ($urandom_range(0, 3) == 0) ? $urandom_range(D, D + 8)
                                               : $urandom_range(1, D + 2);
      end
      btn_in = lvl;
      run_left--;
      reset = ($urandom_range(0, 299) == 0);
      @(negedge clock);
    end
    reset = 1'b0;
    repeat (2) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
